// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: drives the ROM word address from the fetch PC, buffers returned words in a prefetch FIFO, serves decode via valid/ready.
// Optional misaligned-redirect trap (misalign_err port, ERR state) is compiled in with `define IFETCH_ALIGN_CHK_EN.
module ifetch_ctrl #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [31:0]              rom_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef IFETCH_ALIGN_CHK_EN
    ,
    output logic                     misalign_err
`endif
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef IFETCH_ALIGN_CHK_EN
    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_ERR = 1'b1} state_t;
`else
    typedef enum logic [0:0] {ST_RUN = 1'b0} state_t;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_fetch_pc;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_fifo_pc  [DEPTH];
    logic [31:0]     r_fifo_dat [DEPTH];

    logic            w_run;
    logic            w_pop;
    logic            w_push;
    logic [31:0]     w_redirect_tgt;

`ifdef IFETCH_ALIGN_CHK_EN
    logic            r_misalign_err;
    logic            w_misalign;

    assign w_misalign     = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign w_redirect_tgt = redirect_pc;
    assign misalign_err   = r_misalign_err;
`else
    // Low PC bits are dropped so the fetch PC always stays word aligned.
    assign w_redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

    assign w_run       = (r_state == ST_RUN);
    assign instr_valid = (r_count != '0) & w_run;
    assign w_pop       = instr_valid & instr_ready;
    assign w_push      = fetch_en & ~redirect_valid & w_run &
                         ((r_count < CW'(DEPTH)) | w_pop);

    assign rom_addr    = r_fetch_pc[ADDR_W+1:2];
    assign fifo_count  = r_count;
    assign instr       = instr_valid ? r_fifo_dat[r_rd_ptr] : NOP;
    assign instr_pc    = instr_valid ? r_fifo_pc[r_rd_ptr]  : 32'h0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
`ifdef IFETCH_ALIGN_CHK_EN
                if (w_misalign) w_state_nxt = ST_ERR;
`endif
            end
`ifdef IFETCH_ALIGN_CHK_EN
            ST_ERR:  w_state_nxt = ST_ERR;
`endif
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Redirect wins over push; any same-cycle pop is simply absorbed by the flush.
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_tgt;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_push) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_wr_ptr   <= r_wr_ptr + PW'(1);
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]  <= r_fetch_pc;
            r_fifo_dat[r_wr_ptr] <= rom_data;
        end
    end

`ifdef IFETCH_ALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst_n)          r_misalign_err <= 1'b0;
        else if (w_misalign) r_misalign_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios with literal expectations, then randomized traffic against a queue-based fetch model.
module tb_ifetch_ctrl;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, fetch_en, redirect_valid, instr_ready, instr_valid;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data, redirect_pc, instr, instr_pc;
    logic [1:0]  fifo_count;
`ifdef IFETCH_ALIGN_CHK_EN
    logic        misalign_err;
`endif

    always #5 clk = ~clk;

    logic [31:0] rom [256];
    assign rom_data = rom[rom_addr];

    ifetch_ctrl #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .fifo_count(fifo_count)
`ifdef IFETCH_ALIGN_CHK_EN
        , .misalign_err(misalign_err)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {pc, word} pairs plus the next PC to fetch.
    logic [63:0] mq [$];
    logic [31:0] m_pc  = 32'h0;
    bit          m_err = 0;

    always @(posedge clk) begin : model
        bit pop, push;
        if (!rst_n) begin
            mq.delete();
            m_pc  = 32'h0;
            m_err = 0;
        end else begin
            pop  = (mq.size() != 0) && !m_err && instr_ready;
            push = fetch_en && !redirect_valid && !m_err && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (redirect_valid) begin
                mq.delete();
`ifdef IFETCH_ALIGN_CHK_EN
                m_pc = redirect_pc;
                if (redirect_pc[1:0] != 2'b00) m_err = 1;
`else
                m_pc = {redirect_pc[31:2], 2'b00};
`endif
            end else if (push) begin
                mq.push_back({m_pc, rom[m_pc[9:2]]});
                m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit v;
        if (chk_on) begin
            v = (mq.size() != 0) && !m_err;
            chk("m_valid", instr_valid, v);
            chk("m_count", fifo_count, mq.size());
            chk("m_rom_addr", rom_addr, m_pc[9:2]);
            if (v) begin
                chk("m_instr_pc", instr_pc, mq[0][63:32]);
                chk("m_instr", instr, mq[0][31:0]);
            end else begin
                chk("m_instr_pc_empty", instr_pc, 0);
                chk("m_instr_empty", instr, NOP);
            end
`ifdef IFETCH_ALIGN_CHK_EN
            chk("m_misalign_err", misalign_err, m_err);
`endif
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rst_n = 0; fetch_en = 1; instr_ready = 1; redirect_valid = 0; redirect_pc = 0;
        repeat (2) @(negedge clk);
        chk_on = 1;
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", instr_pc, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_addr", rom_addr, 0);

        // Streaming with ready held high.
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("seq_pc", instr_pc, 4 * k);
            chk("seq_instr", instr, rom[k]);
            chk("seq_addr", rom_addr, k + 1);
        end

        // Backpressure from release.
        rst_n = 0; instr_ready = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk); chk("bp_count1", fifo_count, 1); chk("bp_addr1", rom_addr, 1);
        @(negedge clk); chk("bp_count2", fifo_count, 2); chk("bp_addr2", rom_addr, 2);
        @(negedge clk); chk("bp_hold", fifo_count, 2); chk("bp_addr_hold", rom_addr, 2);
        chk("bp_head", instr_pc, 0);
        instr_ready = 1;
        @(negedge clk); chk("bp_pc4", instr_pc, 32'h4); chk("bp_v4", instr_valid, 1);
        @(negedge clk); chk("bp_pc8", instr_pc, 32'h8); chk("bp_v8", instr_valid, 1);

        // Redirect while full.
        instr_ready = 0;
        @(negedge clk); chk("full_count", fifo_count, 2);
        redirect_valid = 1; redirect_pc = 32'h20;
        @(negedge clk);
        redirect_valid = 0;
        chk("rd_count", fifo_count, 0); chk("rd_valid", instr_valid, 0); chk("rd_addr", rom_addr, 8);
        @(negedge clk); chk("rd_pc", instr_pc, 32'h20); chk("rd_v", instr_valid, 1);

        // fetch_en low: drain two entries, PC holds.
        @(negedge clk); chk("fe_count2", fifo_count, 2); chk("fe_addr", rom_addr, 10);
        fetch_en = 0; instr_ready = 1;
        @(negedge clk); chk("fe_drain1", fifo_count, 1); chk("fe_head", instr_pc, 32'h24);
        @(negedge clk); chk("fe_empty_v", instr_valid, 0); chk("fe_empty_i", instr, NOP);
        chk("fe_hold_addr", rom_addr, 10);
        @(negedge clk); chk("fe_hold_addr2", rom_addr, 10);
        fetch_en = 1;
        @(negedge clk); chk("fe_resume", instr_pc, 32'h28);

        // PC wrap past the ROM size aliases back to word 0.
        redirect_valid = 1; redirect_pc = 32'h3FC;
        @(negedge clk);
        redirect_valid = 0;
        chk("wr_addr255", rom_addr, 255);
        @(negedge clk); chk("wr_pc3fc", instr_pc, 32'h3FC); chk("wr_i255", instr, rom[255]);
        chk("wr_addr0", rom_addr, 0);
        @(negedge clk); chk("wr_pc400", instr_pc, 32'h400); chk("wr_i0", instr, rom[0]);

        // Misaligned redirect.
        redirect_valid = 1; redirect_pc = 32'h22;
        @(negedge clk);
        redirect_valid = 0;
`ifdef IFETCH_ALIGN_CHK_EN
        chk("ma_err", misalign_err, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); chk("ma_blocked", instr_valid, 0);
        end
        rst_n = 0;
        @(negedge clk);
        chk("ma_err_clr", misalign_err, 0);
        rst_n = 1;
`else
        chk("ma_addr", rom_addr, 8);
        @(negedge clk); chk("ma_pc", instr_pc, 32'h20);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst_n          = ($urandom_range(0, 99) != 0);
            fetch_en       = ($urandom_range(0, 9) < 8);
            instr_ready    = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
`ifdef IFETCH_ALIGN_CHK_EN
            redirect_pc[1:0] = 2'b00;
`endif
            @(negedge clk);
        end

        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch sequencer sitting between the core's decode stage and the 256x32 asynchronous-read instruction ROM.
- Owns the fetch PC and drives the ROM word address each cycle.
- Captures returned words into a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Applies branch/jump redirects by flushing the FIFO and reloading the PC.

Parameters:
- ADDR_W, 8: ROM word-address width (ROM depth 2^ADDR_W words).
- DEPTH, 2: prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: byte PC loaded at reset; must be word aligned.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- fetch_en  in  1  1 = fetching allowed; 0 = hold PC, no new pushes.
- rom_addr  out  ADDR_W  word address to ROM, = fetch_pc[ADDR_W+1:2].
- rom_data  in  32  asynchronous ROM read data for rom_addr.
- redirect_valid  in  1  one-cycle pulse: load redirect_pc and flush.
- redirect_pc  in  32  new byte PC.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode accepts head this cycle.
- instr  out  32  head instruction word; 32'h0000_0013 (NOP) when empty.
- instr_pc  out  32  byte PC of head; 0 when empty.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset, sampled only on clk edge with rst_n=0:
  - fetch_pc=RESET_PC, FIFO empty, fifo_count=0, instr_valid=0.
  - instr=NOP, instr_pc=0, FSM=RUN.
- instr, instr_pc, instr_valid are driven combinationally from the FIFO head register.
- The ROM is combinational, so rom_data corresponds to the current fetch_pc in the same cycle.
- pop = instr_valid & instr_ready.
- push = fetch_en & ~redirect_valid & (FSM==RUN) & (fifo_count<DEPTH | pop).
  - A push stores {fetch_pc, rom_data} at the tail and sets fetch_pc += 4.
  - fetch_pc is 32-bit and wraps at 2^32. rom_addr is a truncation, so PC 0x400 maps to rom_addr 0 (ROM aliasing is intended).
- Full with simultaneous pop and push: both occur; count stays DEPTH; order is preserved.
- Empty: instr_valid=0; instr_ready is ignored.
- Redirect has priority over push:
  - On the edge: FIFO cleared (count=0), fetch_pc=redirect_pc, no push.
  - A pop in the same cycle still completes; decode has consumed the word.
  - Redirect-to-valid latency is 1 cycle: the target's word is pushed on the next edge (if fetch_en=1), and instr_valid is asserted after that edge.
- fetch_en=0: PC and FIFO hold; pops continue, draining the FIFO. A redirect is still accepted.
- Back-to-back redirects: the last one wins; no push occurs between them.
- Reset mid-operation: all state returns to reset values on that edge, regardless of redirect or handshake inputs.
- FSM states:
  - RUN: normal operation.
  - ERR: exists only with the optional feature. Entered as defined there; left only via reset.
- Throughput: 1 instruction/cycle sustained with instr_ready=1.
- Sequential fetch latency: a word is visible at the FIFO head one edge after its address is driven.

Optional Feature:
- Macro: IFETCH_ALIGN_CHK_EN.
- Defined:
  - Adds output misalign_err (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 still flushes the FIFO and loads the PC.
  - It then sets misalign_err=1 (sticky) and moves the FSM to ERR.
  - In ERR: push is blocked, instr_valid=0, misalign_err stays 1 until reset.
- Not defined:
  - No misalign_err port and no ERR state.
  - redirect_pc[1:0] is ignored; fetch_pc is loaded with those bits forced to 00.

Test Plan:
- Reset then release with fetch_en=1, instr_ready=1, ROM words W0..W3:
  - 1 cycle after release: instr_pc=0, instr=W0.
  - Following cycles: instr_pc=4, 8, 12 with matching words; rom_addr=1, 2, 3.
- Backpressure, instr_ready=0 from release:
  - fifo_count goes 1, 2, then holds at 2; fetch_pc holds at 8; head stays pc 0.
  - Raise instr_ready: pc 0, 4, 8 delivered in order, no gaps.
- Redirect while full, redirect_pc=0x20:
  - Next cycle fifo_count=0, instr_valid=0, rom_addr=8.
  - Following cycle instr_pc=0x20, instr_valid=1.
- fetch_en=0 with 2 entries and instr_ready=1:
  - Drains in 2 cycles, then instr_valid=0 and instr=NOP.
  - fetch_pc unchanged; re-enable resumes at the held PC.
- Wrap: redirect to 0x3FC with ready=1:
  - Deliver pc 0x3FC (rom_addr 255), then pc 0x400 with rom_addr 0 returning word W0.
- IFETCH_ALIGN_CHK_EN defined, redirect_pc=0x22:
  - misalign_err=1 next cycle; instr_valid stays 0 for 10 cycles.
  - Reset clears misalign_err.
- IFETCH_ALIGN_CHK_EN undefined, redirect_pc=0x22:
  - Next valid instr_pc=0x20.
